// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : btn_conditioner
// Brief    : Synchronises and debounces the set/check buttons and switch bus,
//            emitting one-cycle release pulses with a captured switch value.
//            Optional switch-bus debouncer enabled by defining SW_STABLE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       set_btn_in,
   input  logic       check_btn_in,
   input  logic [6:0] sw_in,
   output logic       set_pulse,
   output logic       check_pulse,
   output logic [6:0] sw_value,
   output logic       conflict,
   output logic       busy
);

   localparam logic [1:0] IDLE_UP   = 2'd0;
   localparam logic [1:0] WAIT_DOWN = 2'd1;
   localparam logic [1:0] HELD      = 2'd2;
   localparam logic [1:0] WAIT_UP   = 2'd3;

   localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

   // Bit 0 carries the set button, bit 1 the check button.
   logic [1:0] r_btn_meta;
   logic [1:0] r_btn_s;
   logic [6:0] r_sw_meta;
   logic [6:0] r_sw_s;

   logic [1:0] w_release;
   logic [1:0] w_btn_busy;
   logic [6:0] w_sw_src;
   logic       w_sw_busy;

   logic       r_set_pulse;
   logic       r_check_pulse;
   logic       r_conflict;
   logic [6:0] r_sw_value;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_btn_meta <= 2'b00;
         r_btn_s    <= 2'b00;
         r_sw_meta  <= 7'd0;
         r_sw_s     <= 7'd0;
      end else begin
         r_btn_meta <= {check_btn_in, set_btn_in};
         r_btn_s    <= r_btn_meta;
         r_sw_meta  <= sw_in;
         r_sw_s     <= r_sw_meta;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic [1:0]       r_state;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_state <= IDLE_UP;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               IDLE_UP: begin
                  if (r_btn_s[gi]) begin
                     r_state <= WAIT_DOWN;
                     r_cnt   <= c_cnt_one;
                  end else begin
                     r_cnt   <= '0;
                  end
               end
               WAIT_DOWN: begin
                  if (!r_btn_s[gi]) begin
                     r_state <= IDLE_UP;
                     r_cnt   <= '0;
                  end else if (r_cnt == c_cnt_max) begin
                     r_state <= HELD;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= r_cnt + c_cnt_one;
                  end
               end
               HELD: begin
                  if (!r_btn_s[gi]) begin
                     r_state <= WAIT_UP;
                     r_cnt   <= c_cnt_one;
                  end
               end
               WAIT_UP: begin
                  if (r_btn_s[gi]) begin
                     r_state <= HELD;
                     r_cnt   <= '0;
                  end else if (r_cnt == c_cnt_max) begin
                     r_state <= IDLE_UP;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt   <= r_cnt + c_cnt_one;
                  end
               end
            endcase
         end
      end

      // Release is decoded from the same condition that returns the FSM to IDLE_UP.
      assign w_release[gi]  = (r_state == WAIT_UP) && !r_btn_s[gi] && (r_cnt == c_cnt_max);
      assign w_btn_busy[gi] = (r_state != IDLE_UP) || (r_cnt != '0);
   end

`ifdef SW_STABLE_EN
   logic [6:0]       r_sw_last;
   logic [6:0]       r_sw_stable;
   logic [CNT_W-1:0] r_sw_cnt;

   // The counter only runs while a changed value is pending and unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sw_last   <= 7'd0;
         r_sw_stable <= 7'd0;
         r_sw_cnt    <= '0;
      end else begin
         r_sw_last <= r_sw_s;
         if (r_sw_s != r_sw_last || r_sw_s == r_sw_stable) begin
            r_sw_cnt <= '0;
         end else if (r_sw_cnt == c_cnt_max) begin
            r_sw_stable <= r_sw_s;
            r_sw_cnt    <= '0;
         end else begin
            r_sw_cnt <= r_sw_cnt + c_cnt_one;
         end
      end
   end

   assign w_sw_src  = r_sw_stable;
   assign w_sw_busy = (r_sw_cnt != '0);
`else
   assign w_sw_src  = r_sw_s;
   assign w_sw_busy = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_set_pulse   <= 1'b0;
         r_check_pulse <= 1'b0;
         r_conflict    <= 1'b0;
         r_sw_value    <= 7'd0;
      end else begin
         r_check_pulse <= w_release[1];
         r_set_pulse   <= w_release[0] & ~w_release[1];
         r_conflict    <= &w_release;
         if (|w_release) begin
            r_sw_value <= w_sw_src;
         end
      end
   end

   assign set_pulse   = r_set_pulse;
   assign check_pulse = r_check_pulse;
   assign conflict    = r_conflict;
   assign sw_value    = r_sw_value;
   assign busy        = (|w_btn_busy) | w_sw_busy;

endmodule
`default_nettype wire
